// File: rtl/enc_bundler_acc.sv
// Bundling accumulator: sums N_IN bound hypervectors per bit over N_BEATS beats
// and thresholds the per-bit counts into one sparse encoded hypervector per frame.
module enc_bundler_acc #(
    parameter int unsigned HV_DIM  = 1024,
    parameter int unsigned N_IN    = 10,
    parameter int unsigned N_BEATS = 8,
    parameter int unsigned THRESH  = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start_frame,
    input  logic                         in_valid,
    input  logic [N_IN-1:0][HV_DIM-1:0]  shifted_hv,
    output logic                         busy,
    output logic                         encoded_valid,
    output logic [HV_DIM-1:0]            encoded_hv
);

    localparam int unsigned CNT_W  = $clog2(N_IN * N_BEATS + 1);
    localparam int unsigned COL_W  = $clog2(N_IN + 1);
    localparam int unsigned BEAT_W = $clog2(N_BEATS + 1);

    localparam logic [CNT_W-1:0]  THR_C     = CNT_W'(THRESH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_THRESH
    } state_t;

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]    r_cnt [HV_DIM];
    logic                r_busy;
    logic                r_valid;
    logic [HV_DIM-1:0]   r_hv;

    logic [COL_W-1:0]    w_col_sum [HV_DIM];
    logic [HV_DIM-1:0]   w_thr_hv;

    // Per-bit population count across the N_IN inputs of the current beat
    always_comb begin
        for (int unsigned b = 0; b < HV_DIM; b++) begin
            w_col_sum[b] = '0;
            for (int unsigned i = 0; i < N_IN; i++) begin
                w_col_sum[b] = w_col_sum[b] + COL_W'(shifted_hv[i][b]);
            end
        end
    end

    always_comb begin
        w_thr_hv = '0;
        for (int unsigned b = 0; b < HV_DIM; b++) begin
            w_thr_hv[b] = (r_cnt[b] >= THR_C);
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_hv       <= '0;
            for (int unsigned b = 0; b < HV_DIM; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_frame) begin
                        for (int unsigned b = 0; b < HV_DIM; b++) begin
                            r_cnt[b] <= '0;
                        end
                        r_beat_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        for (int unsigned b = 0; b < HV_DIM; b++) begin
                            r_cnt[b] <= r_cnt[b] + CNT_W'(w_col_sum[b]);
                        end
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state <= S_THRESH;
                        end
                    end
                end
                S_THRESH: begin
                    r_hv    <= w_thr_hv;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign encoded_valid = r_valid;
    assign encoded_hv    = r_hv;

endmodule

// File: tb/tb_enc_bundler_acc.sv
// Directed and randomized frames for enc_bundler_acc, checked against a per-bit
// counting model built directly from the bundling/threshold rules.
module tb_enc_bundler_acc;

    localparam int unsigned HV_DIM  = 16;
    localparam int unsigned N_IN    = 10;
    localparam int unsigned N_BEATS = 2;
    localparam int unsigned THRESH  = 3;

    typedef logic [N_IN-1:0][HV_DIM-1:0] beat_t;

    logic              clk;
    logic              nrst;
    logic              start_frame;
    logic              in_valid;
    beat_t             shifted_hv;
    logic              busy;
    logic              encoded_valid;
    logic [HV_DIM-1:0] encoded_hv;

    int checks = 0;
    int errors = 0;

    int                model_cnt [HV_DIM];
    logic [HV_DIM-1:0] last_exp;

    enc_bundler_acc #(
        .HV_DIM  (HV_DIM),
        .N_IN    (N_IN),
        .N_BEATS (N_BEATS),
        .THRESH  (THRESH)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .start_frame   (start_frame),
        .in_valid      (in_valid),
        .shifted_hv    (shifted_hv),
        .busy          (busy),
        .encoded_valid (encoded_valid),
        .encoded_hv    (encoded_hv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < HV_DIM; b++) model_cnt[b] = 0;
    endtask

    task automatic model_add(input beat_t bt);
        for (int b = 0; b < HV_DIM; b++)
            for (int i = 0; i < N_IN; i++)
                model_cnt[b] += int'(bt[i][b]);
    endtask

    function automatic logic [HV_DIM-1:0] model_result();
        logic [HV_DIM-1:0] r;
        r = '0;
        for (int b = 0; b < HV_DIM; b++) r[b] = (model_cnt[b] >= THRESH);
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t bt;
        for (int i = 0; i < N_IN; i++)
            bt[i] = HV_DIM'($urandom) & HV_DIM'($urandom) & HV_DIM'($urandom);
        return bt;
    endfunction

    // One frame of two beats; chain_in means start_frame was raised during the
    // previous frame's encoded_valid cycle, chain_out raises it in this one's.
    task automatic do_frame(input string tag, input beat_t b0, input beat_t b1,
                            input int gap, input bit noise, input bit mid_start,
                            input bit chain_in, input bit chain_out,
                            input bit use_exp, input logic [HV_DIM-1:0] exp_fixed);
        beat_t             beats [2];
        logic [HV_DIM-1:0] exp;
        beats[0] = b0;
        beats[1] = b1;
        if (chain_in) begin
            @(negedge clk);
            start_frame = 1'b0;
        end else begin
            @(negedge clk);
            if (noise) begin
                in_valid   = 1'b1;
                shifted_hv = '1;
                @(negedge clk);
                chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
            end
            start_frame = 1'b1;
            @(negedge clk);
            start_frame = 1'b0;
            in_valid    = 1'b0;
        end
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        chk({tag, "_hv_hold"}, 32'(encoded_hv), 32'(last_exp));
        model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int g = 0; g < gap; g++) begin
                if (mid_start) start_frame = 1'b1;
                @(negedge clk);
                start_frame = 1'b0;
            end
            in_valid   = 1'b1;
            shifted_hv = beats[k];
            model_add(beats[k]);
            @(negedge clk);
            in_valid   = 1'b0;
            shifted_hv = '0;
        end
        exp = use_exp ? exp_fixed : model_result();
        chk({tag, "_thresh_busy"}, 32'(busy), 32'd1);
        chk({tag, "_thresh_valid"}, 32'(encoded_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(encoded_valid), 32'd1);
        chk({tag, "_hv"}, 32'(encoded_hv), 32'(exp));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        last_exp = exp;
        if (chain_out) begin
            start_frame = 1'b1;
        end else begin
            @(negedge clk);
            chk({tag, "_valid_pulse"}, 32'(encoded_valid), 32'd0);
            chk({tag, "_hv_keep"}, 32'(encoded_hv), 32'(exp));
        end
    endtask

    initial begin
        beat_t zero_b, ones_b, t3_b;
        bit    ch_in, ch_out;

        zero_b = '0;
        ones_b = '1;
        t3_b   = '0;
        for (int i = 0; i < 3; i++) t3_b[i][0] = 1'b1;
        for (int i = 0; i < 2; i++) t3_b[i][1] = 1'b1;
        last_exp    = '0;
        nrst        = 1'b1;
        start_frame = 1'b0;
        in_valid    = 1'b0;
        shifted_hv  = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(encoded_valid), 32'd0);
        chk("rst_hv", 32'(encoded_hv), 32'd0);
        nrst = 1'b0;

        do_frame("zeros",  zero_b, zero_b, 0, 0, 0, 0, 0, 1, 16'h0000);
        do_frame("thr3",   t3_b,   zero_b, 0, 0, 0, 0, 0, 1, 16'h0001);
        do_frame("ones",   ones_b, ones_b, 0, 0, 0, 0, 0, 1, 16'hFFFF);
        do_frame("zeros2", zero_b, zero_b, 0, 0, 0, 0, 0, 1, 16'h0000);
        do_frame("gaps",   t3_b,   zero_b, 3, 1, 1, 0, 0, 1, 16'h0001);
        do_frame("chainA", ones_b, ones_b, 1, 0, 0, 0, 1, 1, 16'hFFFF);
        do_frame("chainB", zero_b, t3_b,   0, 0, 0, 1, 0, 1, 16'h0001);

        // Async reset in the middle of a frame after its first all-ones beat
        @(negedge clk);
        start_frame = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
        in_valid    = 1'b1;
        shifted_hv  = '1;
        @(negedge clk);
        in_valid    = 1'b0;
        shifted_hv  = '0;
        #2;
        nrst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(encoded_valid), 32'd0);
        chk("arst_hv", 32'(encoded_hv), 32'd0);
        last_exp = '0;
        @(negedge clk);
        nrst = 1'b0;
        do_frame("post_rst", zero_b, zero_b, 0, 0, 0, 0, 0, 1, 16'h0000);

        ch_in = 1'b0;
        for (int n = 0; n < 20; n++) begin
            ch_out = 1'($urandom_range(0, 1));
            do_frame("rand", rand_beat(), rand_beat(), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ch_in, ch_out, 0, '0);
            ch_in = ch_out;
        end
        if (ch_in) begin
            @(negedge clk);
            start_frame = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
